fpa_param_seq: RTL

//  Parametrised multi-cycle IEEE-754-style floating-point adder/subtractor; successor to the fixed single-precision fpa.

---
 rtl/fpa_param_seq_if.sv | 32 +++
 rtl/fpa_param_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpa_param_seq_if.sv
// Operand/result handshake bundle for fpa_param_seq.
// master = operand source / result consumer side, slave = the adder itself.
interface fpa_param_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    logic [EXP_W+MAN_W:0] a;
    logic [EXP_W+MAN_W:0] b;
    logic                 decidebit;
    logic                 in_valid;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic                 signbit;
    logic [EXP_W-1:0]     finexponent;
    logic [MAN_W-1:0]     finalmanti;
    logic                 overflow;
    logic                 underflow;
    logic                 invalid;

    modport master (
        output a, b, decidebit, in_valid, out_ready,
        input  in_ready, out_valid, signbit, finexponent, finalmanti,
               overflow, underflow, invalid
    );

    modport slave (
        input  a, b, decidebit, in_valid, out_ready,
        output in_ready, out_valid, signbit, finexponent, finalmanti,
               overflow, underflow, invalid
    );
endinterface

// File: rtl/fpa_param_seq.sv
// Multi-cycle parametrised floating-point adder/subtractor, one op in flight.
// Pipeline of FSM phases: UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE.
// Optional feature macro: FPA_SPECIALS_EN (Inf/NaN handling, overflow to Inf).
// Without it, all-ones exponents are finite and overflow saturates.
module fpa_param_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic             clk,
    input  logic             reset,
    fpa_param_seq_if.slave   bus
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int FW  = MAN_W + 4;          // hidden + fraction + guard/round/sticky
    localparam int SW  = 2 * MAN_W + 4;      // alignment window, wide enough to lose nothing below R
    localparam int XW  = EXP_W + 2;          // signed working exponent (carry + negative after lzc)
    localparam int LZW = $clog2(FW + 1);
    localparam logic [EXP_W-1:0]      EXP_ONES = '1;
    localparam logic signed [XW-1:0]  EXP_OVF  = XW'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t r_state, w_state_next;

    logic [W-1:0]            r_a, r_b;
    logic                    r_op;
    logic                    r_eff_sub, r_res_sign, r_zero_sign, r_zero;
    logic [EXP_W-1:0]        r_big_exp, r_diff;
    logic [MAN_W:0]          r_big_man, r_sml_man;
    logic [FW-1:0]           r_big_ext, r_sml_ext, r_mant;
    logic signed [XW-1:0]    r_exp;
    logic                    r_sign, r_ovf, r_unf;
    logic [EXP_W-1:0]        r_fexp;
    logic [MAN_W-1:0]        r_fman;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state: fixed walk through the phases, stall only in IDLE and DONE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.in_valid) w_state_next = S_UNPACK;
            S_UNPACK: w_state_next = S_ALIGN;
            S_ALIGN:  w_state_next = S_ADD;
            S_ADD:    w_state_next = S_NORM;
            S_NORM:   w_state_next = S_ROUND;
            S_ROUND:  w_state_next = S_DONE;
            S_DONE:   if (bus.out_ready) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Unpack: flush exp==0 to zero, fold decidebit into b's sign, order by magnitude
    logic             w_sa, w_sb, w_a_ge_b;
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W:0]   w_ma, w_mb;
    always_comb begin
        w_sa     = r_a[W-1];
        w_sb     = r_b[W-1] ^ r_op;
        w_ea     = r_a[W-2 -: EXP_W];
        w_eb     = r_b[W-2 -: EXP_W];
        w_ma     = (w_ea == '0) ? '0 : {1'b1, r_a[MAN_W-1:0]};
        w_mb     = (w_eb == '0) ? '0 : {1'b1, r_b[MAN_W-1:0]};
        w_a_ge_b = {w_ea, w_ma} >= {w_eb, w_mb};
    end

`ifdef FPA_SPECIALS_EN
    logic         r_spec, r_spec_inv, r_inv;
    logic [W-1:0] r_spec_res;
    logic         w_spec, w_spec_inv, w_a_inf, w_b_inf, w_any_nan;
    logic [W-1:0] w_spec_res;
    // Special operands decided up front; the regular datapath result is overridden in ROUND
    always_comb begin
        w_a_inf    = (w_ea == EXP_ONES) && (r_a[MAN_W-1:0] == '0);
        w_b_inf    = (w_eb == EXP_ONES) && (r_b[MAN_W-1:0] == '0);
        w_any_nan  = ((w_ea == EXP_ONES) && (r_a[MAN_W-1:0] != '0)) ||
                     ((w_eb == EXP_ONES) && (r_b[MAN_W-1:0] != '0));
        w_spec     = (w_ea == EXP_ONES) || (w_eb == EXP_ONES);
        w_spec_inv = 1'b0;
        w_spec_res = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
        if (!w_any_nan) begin
            if (w_a_inf && w_b_inf && (w_sa != w_sb)) w_spec_inv = 1'b1;
            else if (w_a_inf) w_spec_res = {w_sa, EXP_ONES, {MAN_W{1'b0}}};
            else              w_spec_res = {w_sb, EXP_ONES, {MAN_W{1'b0}}};
        end
    end
`endif

    // Align: smaller operand shifted right, everything below R collapsed into sticky
    logic [SW-1:0] w_win, w_shifted;
    logic [FW-1:0] w_sml_ext;
    always_comb begin
        w_win     = {r_sml_man, {(MAN_W+3){1'b0}}};
        w_shifted = w_win >> r_diff;
        if (32'(r_diff) >= 32'(MAN_W + 3))
            w_sml_ext = {{(FW-1){1'b0}}, |r_sml_man};
        else
            w_sml_ext = {w_shifted[SW-1 -: FW-1], |w_shifted[MAN_W:0]};
    end

    // Add/sub on the extended mantissas; carry-out renormalised right by one
    logic [FW:0]          w_sum;
    logic [FW-1:0]        w_add_mant;
    logic signed [XW-1:0] w_add_exp;
    always_comb begin
        w_sum = r_eff_sub ? ({1'b0, r_big_ext} - {1'b0, r_sml_ext})
                          : ({1'b0, r_big_ext} + {1'b0, r_sml_ext});
        w_add_mant = w_sum[FW] ? {w_sum[FW:2], w_sum[1] | w_sum[0]} : w_sum[FW-1:0];
        w_add_exp  = {2'b00, r_big_exp} + {{(XW-1){1'b0}}, w_sum[FW]};
    end

    // Normalise: leading-zero count, shift left keeping sticky alive in bit 0
    logic [LZW-1:0]       w_lzc;
    logic [FW-1:0]        w_norm_mant;
    logic signed [XW-1:0] w_norm_exp;
    always_comb begin
        w_lzc = '0;
        for (int i = 0; i < FW; i++)
            if (r_mant[i]) w_lzc = LZW'(FW - 1 - i);
        w_norm_mant    = r_mant << w_lzc;
        w_norm_mant[0] = w_norm_mant[0] | r_mant[0];
        w_norm_exp     = r_exp - {{(XW-LZW){1'b0}}, w_lzc};
    end

    // Round to nearest even, then classify zero / underflow / overflow
    logic [MAN_W:0]       w_rnd;
    logic                 w_up, w_res_sign, w_res_ovf, w_res_unf;
    logic signed [XW-1:0] w_rnd_exp;
    logic [EXP_W-1:0]     w_res_exp;
    logic [MAN_W-1:0]     w_res_man;
    always_comb begin
        w_up       = r_mant[2] & (r_mant[1] | r_mant[0] | r_mant[3]);
        w_rnd      = {1'b0, r_mant[FW-2:3]} + {{MAN_W{1'b0}}, w_up};
        w_rnd_exp  = r_exp + {{(XW-1){1'b0}}, w_rnd[MAN_W]};
        w_res_sign = r_res_sign;
        w_res_exp  = w_rnd_exp[EXP_W-1:0];
        w_res_man  = w_rnd[MAN_W-1:0];
        w_res_ovf  = 1'b0;
        w_res_unf  = 1'b0;
        if (r_zero) begin
            w_res_sign = r_zero_sign;
            w_res_exp  = '0;
            w_res_man  = '0;
        end else if (r_exp <= 0) begin
            w_res_exp  = '0;
            w_res_man  = '0;
            w_res_unf  = 1'b1;
        end else if (w_rnd_exp >= EXP_OVF) begin
            w_res_ovf  = 1'b1;
`ifdef FPA_SPECIALS_EN
            w_res_exp  = EXP_ONES;
            w_res_man  = '0;
`else
            w_res_exp  = EXP_ONES - 1'b1;
            w_res_man  = '1;
`endif
        end
    end

    // Datapath registers: each phase writes only the stage it owns
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a <= '0; r_b <= '0; r_op <= 1'b0;
            r_eff_sub <= 1'b0; r_res_sign <= 1'b0; r_zero_sign <= 1'b0; r_zero <= 1'b0;
            r_big_exp <= '0; r_diff <= '0; r_big_man <= '0; r_sml_man <= '0;
            r_big_ext <= '0; r_sml_ext <= '0; r_mant <= '0; r_exp <= '0;
            r_sign <= 1'b0; r_fexp <= '0; r_fman <= '0; r_ovf <= 1'b0; r_unf <= 1'b0;
`ifdef FPA_SPECIALS_EN
            r_spec <= 1'b0; r_spec_inv <= 1'b0; r_spec_res <= '0; r_inv <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (bus.in_valid) begin
                    r_a <= bus.a; r_b <= bus.b; r_op <= bus.decidebit;
                    r_ovf <= 1'b0; r_unf <= 1'b0;
`ifdef FPA_SPECIALS_EN
                    r_inv <= 1'b0;
`endif
                end
                S_UNPACK: begin
                    r_eff_sub   <= w_sa ^ w_sb;
                    r_res_sign  <= w_a_ge_b ? w_sa : w_sb;
                    r_zero_sign <= r_a[W-1] & r_b[W-1] & ~r_op;
                    r_big_exp   <= w_a_ge_b ? w_ea : w_eb;
                    r_diff      <= w_a_ge_b ? (w_ea - w_eb) : (w_eb - w_ea);
                    r_big_man   <= w_a_ge_b ? w_ma : w_mb;
                    r_sml_man   <= w_a_ge_b ? w_mb : w_ma;
`ifdef FPA_SPECIALS_EN
                    r_spec      <= w_spec;
                    r_spec_inv  <= w_spec_inv;
                    r_spec_res  <= w_spec_res;
`endif
                end
                S_ALIGN: begin
                    r_big_ext <= {r_big_man, 3'b000};
                    r_sml_ext <= w_sml_ext;
                end
                S_ADD: begin
                    r_mant <= w_add_mant;
                    r_exp  <= w_add_exp;
                end
                S_NORM: begin
                    r_mant <= w_norm_mant;
                    r_exp  <= w_norm_exp;
                    r_zero <= (r_mant == '0);
                end
                S_ROUND: begin
`ifdef FPA_SPECIALS_EN
                    if (r_spec) begin
                        {r_sign, r_fexp, r_fman} <= r_spec_res;
                        r_ovf <= 1'b0; r_unf <= 1'b0; r_inv <= r_spec_inv;
                    end else begin
                        r_sign <= w_res_sign; r_fexp <= w_res_exp; r_fman <= w_res_man;
                        r_ovf <= w_res_ovf; r_unf <= w_res_unf; r_inv <= 1'b0;
                    end
`else
                    r_sign <= w_res_sign; r_fexp <= w_res_exp; r_fman <= w_res_man;
                    r_ovf  <= w_res_ovf;  r_unf  <= w_res_unf;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (r_state == S_IDLE);
    assign bus.out_valid   = (r_state == S_DONE);
    assign bus.signbit     = r_sign;
    assign bus.finexponent = r_fexp;
    assign bus.finalmanti  = r_fman;
    assign bus.overflow    = r_ovf;
    assign bus.underflow   = r_unf;
`ifdef FPA_SPECIALS_EN
    assign bus.invalid     = r_inv;
`else
    assign bus.invalid     = 1'b0;
`endif
endmodule
